// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// slave = arbiter view, master = requester/memory model view.
interface mem_arbiter_if;
    logic        IF_req;
    logic [31:0] IF_address;
    logic        IF_gnt;
    logic        IF_valid;
    logic [31:0] IF_rdata;

    logic        D_req;
    logic        D_write;
    logic [1:0]  D_length;
    logic        D_signed;
    logic [31:0] D_address;
    logic [31:0] D_wdata;
    logic        D_gnt;
    logic        D_valid;
    logic [31:0] D_rdata;

    logic        MEM_req;
    logic        MEM_write;
    logic [1:0]  MEM_length;
    logic        MEM_signed;
    logic [31:0] MEM_address;
    logic [31:0] MEM_wdata;
    logic        MEM_ready;
    logic [31:0] MEM_rdata;

    logic        BUS_error;

    modport slave (
        input  IF_req, IF_address,
        output IF_gnt, IF_valid, IF_rdata,
        input  D_req, D_write, D_length, D_signed,
        input  D_address, D_wdata,
        output D_gnt, D_valid, D_rdata,
        output MEM_req, MEM_write, MEM_length, MEM_signed,
        output MEM_address, MEM_wdata,
        input  MEM_ready, MEM_rdata,
        output BUS_error
    );

    modport master (
        output IF_req, IF_address,
        input  IF_gnt, IF_valid, IF_rdata,
        output D_req, D_write, D_length, D_signed,
        output D_address, D_wdata,
        input  D_gnt, D_valid, D_rdata,
        input  MEM_req, MEM_write, MEM_length, MEM_signed,
        input  MEM_address, MEM_wdata,
        output MEM_ready, MEM_rdata,
        input  BUS_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: data-over-fetch priority with a
// starvation guard for fetch and a wait-state timeout abort.
module mem_arbiter #(
    parameter int DATA_MAX_RUN = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [3:0] RUN_MAX  = 4'(DATA_MAX_RUN);
    localparam logic [7:0] BUSY_MAX = 8'(TIMEOUT);

    state_t      r_state;
    logic [3:0]  r_run_cnt;
    logic [7:0]  r_busy_cnt;

    logic        r_if_gnt;
    logic        r_if_valid;
    logic [31:0] r_if_rdata;
    logic        r_d_gnt;
    logic        r_d_valid;
    logic [31:0] r_d_rdata;
    logic        r_mem_req;
    logic        r_mem_write;
    logic [1:0]  r_mem_length;
    logic        r_mem_signed;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wdata;
    logic        r_bus_error;

    logic        w_if_wins;
    logic        w_d_wins;
    logic        w_done;
    logic [3:0]  w_run_next;
    logic [31:0] w_rdata;

    // Fetch only beats a pending data request once data has had its run.
    assign w_if_wins = bus.IF_req &&
                       (!bus.D_req || r_run_cnt == RUN_MAX);
    assign w_d_wins  = bus.D_req && !w_if_wins;

    assign w_done    = bus.MEM_ready || r_busy_cnt == BUSY_MAX;
    assign w_rdata   = bus.MEM_ready ? bus.MEM_rdata : 32'd0;

    always_comb begin
        w_run_next = 4'd0;
        if (bus.IF_req) begin
            w_run_next = (r_run_cnt < RUN_MAX) ?
                         r_run_cnt + 4'd1 : r_run_cnt;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_state       <= IDLE;
            r_run_cnt     <= 4'd0;
            r_busy_cnt    <= 8'd0;
            r_if_gnt      <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_rdata    <= 32'd0;
            r_d_gnt       <= 1'b0;
            r_d_valid     <= 1'b0;
            r_d_rdata     <= 32'd0;
            r_mem_req     <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_length  <= 2'd0;
            r_mem_signed  <= 1'b0;
            r_mem_address <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_bus_error   <= 1'b0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_bus_error <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_if_wins) begin
                        r_state       <= FETCH;
                        r_if_gnt      <= 1'b1;
                        r_run_cnt     <= 4'd0;
                        r_busy_cnt    <= 8'd1;
                        r_mem_req     <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_length  <= 2'b11;
                        r_mem_signed  <= 1'b0;
                        r_mem_address <= bus.IF_address;
                        r_mem_wdata   <= 32'd0;
                    end else if (w_d_wins) begin
                        r_state       <= DATA;
                        r_d_gnt       <= 1'b1;
                        r_run_cnt     <= w_run_next;
                        r_busy_cnt    <= 8'd1;
                        r_mem_req     <= 1'b1;
                        r_mem_write   <= bus.D_write;
                        r_mem_length  <= bus.D_length;
                        r_mem_signed  <= bus.D_signed;
                        r_mem_address <= bus.D_address;
                        r_mem_wdata   <= bus.D_wdata;
                    end
                end
                FETCH, DATA: begin
                    if (w_done) begin
                        r_state       <= IDLE;
                        r_busy_cnt    <= 8'd0;
                        r_bus_error   <= !bus.MEM_ready;
                        r_mem_req     <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_mem_length  <= 2'd0;
                        r_mem_signed  <= 1'b0;
                        r_mem_address <= 32'd0;
                        r_mem_wdata   <= 32'd0;
                        if (r_state == FETCH) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= w_rdata;
                        end else begin
                            r_d_valid <= 1'b1;
                            // Stores never disturb the last load result.
                            if (!r_mem_write) begin
                                r_d_rdata <= w_rdata;
                            end
                        end
                    end else begin
                        r_busy_cnt <= r_busy_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.IF_gnt      = r_if_gnt;
    assign bus.IF_valid    = r_if_valid;
    assign bus.IF_rdata    = r_if_rdata;
    assign bus.D_gnt       = r_d_gnt;
    assign bus.D_valid     = r_d_valid;
    assign bus.D_rdata     = r_d_rdata;
    assign bus.MEM_req     = r_mem_req;
    assign bus.MEM_write   = r_mem_write;
    assign bus.MEM_length  = r_mem_length;
    assign bus.MEM_signed  = r_mem_signed;
    assign bus.MEM_address = r_mem_address;
    assign bus.MEM_wdata   = r_mem_wdata;
    assign bus.BUS_error   = r_bus_error;
endmodule
